// File: rtl/sfx_sequencer_if.sv
// rtl/sfx_sequencer_if.sv - request/rejection interface between the level FSM and the sfx sequencer
interface sfx_sequencer_if;
   logic       play_sound;
   logic [3:0] sound_request;
   logic       dropped;

   modport master (output play_sound, output sound_request, input dropped);
   modport slave  (input play_sound, input sound_request, output dropped);
endinterface

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - priority sound-effect sequencer driving a 1-bit square wave
// Define SFX_QUEUE_EN to keep the most recent rejected request in a one-entry queue.
module sfx_sequencer #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int UNIT_CYCLES = 2_500_000,
   parameter int GAP_CYCLES  = 250_000
) (
   input  logic             clk,
   input  logic             resetN,
   sfx_sequencer_if.slave   req,
   output logic             o_audio_out,
   output logic             o_busy,
   output logic [3:0]       o_current_sound
);

   localparam int DW = $clog2(12 * UNIT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   // 131 Hz is the lowest tone in the table, so it bounds every half-period.
   localparam int HP_MAX = CLK_HZ / (2 * 131);
   if (HP_MAX > 24'hFFFFFF) begin : g_hp_range
      $error("sfx_sequencer: tone half-period exceeds 24 bits");
   end

   localparam logic [23:0] HP_C3 = 24'(HP_MAX);
   localparam logic [23:0] HP_C4 = 24'(CLK_HZ / (2 * 262));
   localparam logic [23:0] HP_E4 = 24'(CLK_HZ / (2 * 330));
   localparam logic [23:0] HP_G4 = 24'(CLK_HZ / (2 * 392));
   localparam logic [23:0] HP_A4 = 24'(CLK_HZ / (2 * 440));
   localparam logic [23:0] HP_C5 = 24'(CLK_HZ / (2 * 523));
   localparam logic [23:0] HP_E5 = 24'(CLK_HZ / (2 * 659));
   localparam logic [23:0] HP_G5 = 24'(CLK_HZ / (2 * 784));
   localparam logic [23:0] HP_C6 = 24'(CLK_HZ / (2 * 1047));
   localparam logic [23:0] HP_E6 = 24'(CLK_HZ / (2 * 1319));
   localparam logic [23:0] HP_G6 = 24'(CLK_HZ / (2 * 1568));

   localparam logic [DW-1:0] L2  = DW'(2 * UNIT_CYCLES - 1);
   localparam logic [DW-1:0] L3  = DW'(3 * UNIT_CYCLES - 1);
   localparam logic [DW-1:0] L4  = DW'(4 * UNIT_CYCLES - 1);
   localparam logic [DW-1:0] L6  = DW'(6 * UNIT_CYCLES - 1);
   localparam logic [DW-1:0] L8  = DW'(8 * UNIT_CYCLES - 1);
   localparam logic [DW-1:0] L12 = DW'(12 * UNIT_CYCLES - 1);

   function automatic logic [23:0] note_hp(input logic [3:0] s, input logic [1:0] n);
      logic [23:0] hp;
      hp = '0;
      case (s)
         4'd1: case (n) 2'd0: hp = HP_C5; 2'd1: hp = HP_E5; 2'd2: hp = HP_G5; default: hp = HP_C6; endcase
         4'd2: case (n) 2'd0: hp = HP_G4; 2'd1: hp = HP_E4; default: hp = HP_C4; endcase
         4'd3: hp = HP_A4;
         4'd4: hp = (n == 2'd0) ? HP_E6 : HP_G6;
         4'd5: hp = HP_C3;
         default: hp = '0;
      endcase
      return hp;
   endfunction

   // Last cycle index of each note's duration.
   function automatic logic [DW-1:0] note_lim(input logic [3:0] s, input logic [1:0] n);
      logic [DW-1:0] lim;
      lim = '0;
      case (s)
         4'd1: lim = (n == 2'd3) ? L8 : L4;
         4'd2: lim = (n == 2'd2) ? L12 : L6;
         4'd3: lim = L2;
         4'd4: lim = (n == 2'd0) ? L2 : L3;
         4'd5: lim = L3;
         default: lim = '0;
      endcase
      return lim;
   endfunction

   function automatic logic [2:0] note_count(input logic [3:0] s);
      case (s)
         4'd1:    return 3'd4;
         4'd2:    return 3'd3;
         4'd4:    return 3'd2;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [1:0] prio(input logic [3:0] s);
      case (s)
         4'd1, 4'd2: return 2'd2;
         4'd4, 4'd5: return 2'd1;
         default:    return 2'd0;
      endcase
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   state_t          r_state,   w_state_n;
   logic [3:0]      r_sound,   w_sound_n;
   logic [1:0]      r_idx,     w_idx_n;
   logic [23:0]     r_tone,    w_tone_n;
   logic [DW-1:0]   r_dur,     w_dur_n;
   logic [GW-1:0]   r_gap,     w_gap_n;
   logic            r_audio,   w_audio_n;
   logic            r_dropped, w_dropped_n;
`ifdef SFX_QUEUE_EN
   logic            r_qv,      w_qv_n;
   logic [3:0]      r_qs,      w_qs_n;
`endif

   logic            w_valid, w_req, w_accept, w_reject, w_last;
   logic [23:0]     w_hp;
   logic [DW-1:0]   w_lim;

   assign w_valid  = (req.sound_request >= 4'd1) && (req.sound_request <= 4'd5);
   assign w_req    = req.play_sound && w_valid;
   assign w_accept = w_req && ((r_state == S_IDLE) || (prio(req.sound_request) >= prio(r_sound)));
   assign w_reject = w_req && !w_accept;
   assign w_hp     = note_hp(r_sound, r_idx);
   assign w_lim    = note_lim(r_sound, r_idx);
   assign w_last   = ({1'b0, r_idx} + 3'd1) >= note_count(r_sound);

   always_comb begin
      w_state_n   = r_state;
      w_sound_n   = r_sound;
      w_idx_n     = r_idx;
      w_tone_n    = r_tone;
      w_dur_n     = r_dur;
      w_gap_n     = r_gap;
      w_audio_n   = r_audio;
      w_dropped_n = 1'b0;
`ifdef SFX_QUEUE_EN
      w_qv_n      = r_qv;
      w_qs_n      = r_qs;
`endif
      // An accept outranks any note or gap expiry on the same edge.
      if (w_accept) begin
         w_state_n = S_PLAY;
         w_sound_n = req.sound_request;
         w_idx_n   = '0;
         w_tone_n  = '0;
         w_dur_n   = '0;
         w_gap_n   = '0;
         w_audio_n = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_PLAY: begin
               if (r_dur == w_lim) begin
                  w_dur_n   = '0;
                  w_tone_n  = '0;
                  w_audio_n = 1'b0;
                  if (!w_last) begin
                     w_state_n = S_GAP;
                     w_gap_n   = '0;
                  end
`ifdef SFX_QUEUE_EN
                  else if (r_qv) begin
                     w_sound_n = r_qs;
                     w_idx_n   = '0;
                     w_qv_n    = 1'b0;
                     w_qs_n    = '0;
                  end
`endif
                  else begin
                     w_state_n = S_IDLE;
                     w_sound_n = '0;
                     w_idx_n   = '0;
                  end
               end else begin
                  w_dur_n = r_dur + 1'b1;
                  if (w_hp != '0) begin
                     if (r_tone == w_hp - 24'd1) begin
                        w_tone_n  = '0;
                        w_audio_n = ~r_audio;
                     end else begin
                        w_tone_n  = r_tone + 24'd1;
                     end
                  end
               end
            end
            S_GAP: begin
               if (r_gap == GW'(GAP_CYCLES - 1)) begin
                  w_state_n = S_PLAY;
                  w_idx_n   = r_idx + 2'd1;
                  w_gap_n   = '0;
               end else begin
                  w_gap_n   = r_gap + 1'b1;
               end
            end
            default: w_state_n = S_IDLE;
         endcase
      end
`ifdef SFX_QUEUE_EN
      // Overwriting a still-pending entry is the only case that loses a request.
      if (w_reject) begin
         w_dropped_n = w_qv_n;
         w_qv_n      = 1'b1;
         w_qs_n      = req.sound_request;
      end
`else
      w_dropped_n = w_reject;
`endif
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state   <= S_IDLE;
         r_sound   <= '0;
         r_idx     <= '0;
         r_tone    <= '0;
         r_dur     <= '0;
         r_gap     <= '0;
         r_audio   <= 1'b0;
         r_dropped <= 1'b0;
`ifdef SFX_QUEUE_EN
         r_qv      <= 1'b0;
         r_qs      <= '0;
`endif
      end else begin
         r_state   <= w_state_n;
         r_sound   <= w_sound_n;
         r_idx     <= w_idx_n;
         r_tone    <= w_tone_n;
         r_dur     <= w_dur_n;
         r_gap     <= w_gap_n;
         r_audio   <= w_audio_n;
         r_dropped <= w_dropped_n;
`ifdef SFX_QUEUE_EN
         r_qv      <= w_qv_n;
         r_qs      <= w_qs_n;
`endif
      end
   end

   assign o_audio_out     = r_audio;
   assign o_busy          = (r_state != S_IDLE);
   assign o_current_sound = r_sound;
   assign req.dropped     = r_dropped;

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Sound-effect sequencer directly downstream of the level state machine. It consumes the one-cycle `play_sound` pulse and the 4-bit `sound_request` code. It plays the matching short note sequence as a 1-bit square wave for the board audio driver. Requests arbitrate by priority, so end-of-level jingles are never cut off by claw or loot effects.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz; used to derive tone half-periods.
UNIT_CYCLES, 2_500_000, clock cycles per duration unit (default 50 ms).
GAP_CYCLES, 250_000, silent cycles inserted between consecutive notes of one sound.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
play_sound  in  1  one-cycle request strobe
sound_request  in  4  1=Win, 2=Loss, 3=Claw, 4=Gold, 5=Stone; all other codes invalid
audio_out  out  1  square-wave audio output
busy  out  1  high while a sound is in PLAY or GAP
current_sound  out  4  code of the sound playing; 0 when idle
dropped  out  1  one-cycle pulse when a valid request is rejected

Behaviour:
- Reset (already decided): reset resetN, asynchronous, active-low; clock clk. All state clears to IDLE. Reset values: audio_out=0, busy=0, current_sound=0, dropped=0, all counters 0. Reset mid-sound silences the output immediately.
- Note table is fixed internal ROM, max 4 notes per sound. Each note is (frequency Hz, units); 0 Hz means silence.
  - 1 Win: 523,4 / 659,4 / 784,4 / 1047,8
  - 2 Loss: 392,6 / 330,6 / 262,12
  - 3 Claw: 440,2
  - 4 Gold: 1319,2 / 1568,3
  - 5 Stone: 131,3
- Tone half-period = floor(CLK_HZ / (2*f)), computed at elaboration. Width is 24 bits; a compile-time check fails if any half-period exceeds 24 bits.
- Priority: codes 1 and 2 = 2; codes 4 and 5 = 1; code 3 = 0.
- Acceptance: sampled on a clk edge where play_sound=1 and the code is valid.
  - Accepted when IDLE, or when the new priority is >= the current priority.
  - Acceptance restarts from note 0 of the new sound. This includes re-requesting the same sound.
  - Rejected (lower priority) -> dropped=1 for exactly one cycle; current playback is unaffected.
  - Invalid codes are ignored silently; dropped stays 0.
- States:
  - IDLE: audio_out=0. On accept -> PLAY.
  - PLAY: square wave from the tone counter. Duration counter runs units*UNIT_CYCLES cycles. At expiry: more notes -> GAP; otherwise -> IDLE.
  - GAP: audio_out=0 for GAP_CYCLES cycles, then load the next note -> PLAY.
- Latency:
  - The cycle after the accepting edge: busy=1, current_sound=new code, audio_out=0, tone and duration counters cleared.
  - audio_out first toggles high exactly half-period cycles later.
  - It toggles every half-period thereafter.
- Silence notes (f=0): audio_out held 0 for the full duration.
- End of the last note: next cycle IDLE, busy=0, current_sound=0, audio_out=0. No trailing gap.
- Simultaneous accept and note/gap expiry: accept wins; the expiry is discarded.
- Duration counter width is ceil(log2(12*UNIT_CYCLES+1)).

Optional Feature:
SFX_QUEUE_EN:
- Defined: a one-entry queue holds the most recent rejected request instead of dropping it; dropped stays 0. A later rejected request overwrites the entry and pulses dropped.
- When the current sound ends, the queued sound starts the next cycle; busy stays 1 and the queue clears.
- An accepted higher-or-equal request does not clear the queue.
- Undefined: no queue; rejection behaves as described in Behaviour.

Test Plan:
Unless noted, all tests use CLK_HZ=8800, UNIT_CYCLES=200, GAP_CYCLES=20.
- Claw pulse (code 3) from IDLE -> busy=1 next cycle. audio_out period 20 cycles (half-period 10). Busy for exactly 400 cycles, then current_sound=0.
- Win (code 1) -> four notes with half-periods 8, 6, 5, 4. 20-cycle silent gaps between notes. Total busy = 4000+60 = 4060 cycles.
- Win playing, Gold pulse (code 4) -> dropped pulses once; Win completes unchanged. With SFX_QUEUE_EN: Gold starts the cycle after Win ends; half-period 3 for 400 cycles.
- Gold playing, Loss pulse (code 2) -> Loss restarts at note 0 the next cycle; current_sound=2; dropped=0.
- Invalid code 7 pulsed in IDLE and mid-Claw -> no state change, dropped=0.
- resetN asserted mid-Win at cycle 1500 -> asynchronously audio_out=0, busy=0, current_sound=0. After release, a Stone request plays normally (half-period 33, 600 cycles).
